// File: rtl/alu_issue_seq.sv
// Issue sequencer in front of the ALU: IDLE -> DEC -> EXEC -> WB, with illegal-op bypass DEC -> IDLE.
// Optional perf counters are enabled with `define ALU_ISSUE_PERF_EN; otherwise retired_cnt/illegal_cnt read 0.
module alu_issue_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic                rf_rd_en,
    output logic [ADDR_W-1:0]   rf_rs1_addr,
    output logic [ADDR_W-1:0]   rf_rs2_addr,
    input  logic [DATA_W-1:0]   rf_rs1_data,
    input  logic [DATA_W-1:0]   rf_rs2_data,
    output logic                alu_enable,
    output logic [3:0]          alu_opcode,
    output logic                alu_src_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [24:0]         alu_imm,
    output logic [DATA_W-1:0]   alu_shift_amt,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic                alu_z,
    input  logic                alu_c,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic [DATA_W-1:0]   wb_hi,
    output logic                z_flag_q,
    output logic                c_flag_q,
    output logic                illegal,
    output logic                busy,
    output logic [15:0]         retired_cnt,
    output logic [15:0]         illegal_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXEC, S_WB} state_t;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   wb_hi_q, wb_hi_d;
    logic                z_flag_d, c_flag_d;

    logic [3:0]          op;
    logic                imm_sel;
    logic [4:0]          rd, rs1, rs2;
    logic [16:0]         imm;
    logic                legal;

    assign op      = instr_q[31:28];
    assign imm_sel = instr_q[27];
    assign rd      = instr_q[26:22];
    assign rs1     = instr_q[21:17];
    assign rs2     = instr_q[16:12];
    assign imm     = instr_q[16:0];
    assign legal   = (op != 4'hE) && (op != 4'hF);

    assign busy    = (state_q != S_IDLE);
    assign wb_data = wb_data_q;
    assign wb_hi   = wb_hi_q;

    // NOTE: every flop, including the captured result and flags, is cleared by reset so an abort leaves nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            wb_data_q <= '0;
            wb_hi_q   <= '0;
            z_flag_q  <= 1'b0;
            c_flag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            wb_data_q <= wb_data_d;
            wb_hi_q   <= wb_hi_d;
            z_flag_q  <= z_flag_d;
            c_flag_q  <= c_flag_d;
        end
    end

    // NOTE: all outputs and next-state values get a default first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        wb_data_d     = wb_data_q;
        wb_hi_d       = wb_hi_q;
        z_flag_d      = z_flag_q;
        c_flag_d      = c_flag_q;
        instr_ready   = 1'b0;
        rf_rd_en      = 1'b0;
        rf_rs1_addr   = '0;
        rf_rs2_addr   = '0;
        alu_enable    = 1'b0;
        alu_opcode    = '0;
        alu_src_sel   = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_imm       = '0;
        alu_shift_amt = '0;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        illegal       = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (legal) begin
                    rf_rd_en    = 1'b1;
                    rf_rs1_addr = rs1;
                    rf_rs2_addr = imm_sel ? '0 : rs2;
                    state_d     = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                // Register-file data arrives this cycle, one cycle after the read strobe.
                alu_enable    = 1'b1;
                alu_opcode    = op;
                alu_src_sel   = imm_sel;
                alu_a         = rf_rs1_data;
                alu_b         = rf_rs2_data;
                alu_imm       = {8'b0, imm};
                alu_shift_amt = {{(DATA_W-5){1'b0}}, imm_sel ? imm[4:0] : rf_rs2_data[4:0]};
                wb_data_d     = alu_result[DATA_W-1:0];
                wb_hi_d       = alu_result[2*DATA_W-1:DATA_W];
                z_flag_d      = alu_z;
                c_flag_d      = alu_c;
                state_d       = (rd == 5'd0) ? S_IDLE : S_WB;
            end
            S_WB: begin
                wb_valid = 1'b1;
                wb_addr  = rd;
                if (wb_ready) state_d = S_IDLE;
            end
        endcase
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] retired_q, illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            illegal_q <= '0;
        end else begin
            if (state_q == S_EXEC) retired_q <= retired_q + 16'd1;
            if (illegal)           illegal_q <= illegal_q + 16'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign illegal_cnt = illegal_q;
`else
    assign retired_cnt = '0;
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: register-file and ALU responders, reference model, decoupled monitor.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        rf_rd_en;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data = '0, rf_rs2_data = '0;
    logic        alu_enable;
    logic [3:0]  alu_opcode;
    logic        alu_src_sel;
    logic [31:0] alu_a, alu_b;
    logic [24:0] alu_imm;
    logic [31:0] alu_shift_amt;
    logic [63:0] alu_result;
    logic        alu_z, alu_c;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_hi;
    logic        z_flag_q, c_flag_q;
    logic        illegal, busy;
    logic [15:0] retired_cnt, illegal_cnt;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_rd_en(rf_rd_en), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_src_sel(alu_src_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_shift_amt(alu_shift_amt),
        .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_hi(wb_hi),
        .z_flag_q(z_flag_q), .c_flag_q(c_flag_q),
        .illegal(illegal), .busy(busy),
        .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
    );

    typedef struct { logic [4:0] addr; logic [31:0] lo; logic [31:0] hi; } wb_exp_t;
    typedef struct { logic z; logic c; } fl_exp_t;

    logic [31:0] regs [32];
    wb_exp_t     wbq[$];
    fl_exp_t     flq[$];
    logic        mz = 1'b0, mc = 1'b0;
    int          mret = 0, mill = 0;
    int          rdy_mode = 0;
    int          checks = 0, errors = 0;
    logic        mon_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: {z, c, result64}. Carry is the unsigned carry/borrow; MUL carry means non-zero high half.
    function automatic logic [65:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] t;
        logic [63:0] r;
        logic        c;
        t = '0; r = '0; c = 1'b0;
        case (op)
            4'h0: begin t = {1'b0, a} + {1'b0, b}; r = {32'b0, t[31:0]}; c = t[32]; end
            4'h1: begin t = {1'b0, a} - {1'b0, b}; r = {32'b0, t[31:0]}; c = t[32]; end
            4'h2: begin r = {32'b0, a} * {32'b0, b}; c = |r[63:32]; end
            4'h3: r = {32'b0, a & b};
            4'h4: r = {32'b0, a | b};
            4'h5: r = {32'b0, ~a};
            4'h6: r = {32'b0, ~(a | b)};
            4'h7: r = {32'b0, ~(a & b)};
            4'h8: r = {32'b0, a ^ b};
            4'h9: r = {32'b0, ~(a ^ b)};
            4'hA: begin t = {1'b0, a} + 33'd1; r = {32'b0, t[31:0]}; c = t[32]; end
            4'hB: begin t = {1'b0, a} - 33'd1; r = {32'b0, t[31:0]}; c = t[32]; end
            4'hC: r = {32'b0, a << sh};
            4'hD: r = {32'b0, a >> sh};
            default: ;
        endcase
        return {(r[31:0] == 32'd0), c, r};
    endfunction

    // ALU responder: reacts only to what the sequencer drives.
    logic [65:0] alu_out;
    always_comb begin
        alu_out = '0;
        if (alu_enable)
            alu_out = alu_fn(alu_opcode, alu_a, alu_src_sel ? {7'b0, alu_imm} : alu_b, alu_shift_amt[4:0]);
    end
    assign alu_result = alu_out[63:0];
    assign alu_c      = alu_out[64];
    assign alu_z      = alu_out[65];

    // Register file: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rs1_data <= regs[rf_rs1_addr];
            rf_rs2_data <= regs[rf_rs2_addr];
        end else begin
            rf_rs1_data <= $urandom;
            rf_rs2_data <= $urandom;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wb_ready = 1'b1;
                1:       wb_ready = 1'($urandom_range(0, 1));
                default: wb_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic i, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [16:0] f);
        return {op, i, rd, rs1, f};
    endfunction

    task automatic push_model(input logic [31:0] w);
        logic [3:0]  op;
        logic        i;
        logic [4:0]  rd, rs1, rs2;
        logic [16:0] imm;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [65:0] res;
        op = w[31:28]; i = w[27]; rd = w[26:22]; rs1 = w[21:17]; rs2 = w[16:12]; imm = w[16:0];
        if (op >= 4'hE) begin
            mill++;
        end else begin
            b   = i ? {15'b0, imm} : regs[rs2];
            sh  = i ? imm[4:0] : regs[rs2][4:0];
            res = alu_fn(op, regs[rs1], b, sh);
            flq.push_back('{z: res[65], c: res[64]});
            mz = res[65];
            mc = res[64];
            if (rd != 5'd0) wbq.push_back('{addr: rd, lo: res[31:0], hi: res[63:32]});
            mret++;
        end
    endtask

    // Present w from a falling edge until accepted; returns just after the accepting edge.
    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", instr_ready, 1);
        if (instr_ready) begin
            @(posedge clk);
            push_model(w);
            #1;
        end
        instr_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout_busy", busy, 0);
    endtask

    task automatic check_counters(input string tag);
`ifdef ALU_ISSUE_PERF_EN
        check({tag, "_retired_cnt"}, retired_cnt, 64'(16'(mret)));
        check({tag, "_illegal_cnt"}, illegal_cnt, 64'(16'(mill)));
`else
        check({tag, "_retired_cnt"}, retired_cnt, 0);
        check({tag, "_illegal_cnt"}, illegal_cnt, 0);
`endif
    endtask

    // Monitor: pops expected flags after every EXEC and expected writebacks on every wb handshake.
    initial begin
        fl_exp_t fe;
        wb_exp_t we;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wbq.delete();
                flq.delete();
                mon_prev = 1'b0;
            end else begin
                if (mon_prev) begin
                    check("flag_expected", flq.size() != 0, 1);
                    if (flq.size() != 0) begin
                        fe = flq.pop_front();
                        check("z_flag", z_flag_q, fe.z);
                        check("c_flag", c_flag_q, fe.c);
                    end
                end
                if (wb_valid) begin
                    check("wb_expected", wbq.size() != 0, 1);
                    if (wbq.size() != 0) begin
                        we = wbq[0];
                        check("wb_addr", wb_addr, we.addr);
                        check("wb_data", wb_data, we.lo);
                        check("wb_hi", wb_hi, we.hi);
                        if (wb_ready) void'(wbq.pop_front());
                    end
                end
                if (!alu_enable)
                    check("alu_idle_zero", |{alu_opcode, alu_src_sel, alu_a, alu_b, alu_imm, alu_shift_amt}, 0);
                else
                    check("shift_amt_upper", alu_shift_amt[31:5], 0);
                mon_prev = alu_enable;
            end
        end
    end

    initial begin
        logic [31:0] w2;
        int          n;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'd5; regs[2] = 32'd7; regs[9] = 32'd9;
        regs[10] = 32'hFFFF_FFFF; regs[11] = 32'd2; regs[13] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_instr_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outputs_zero", |{rf_rd_en, rf_rs1_addr, rf_rs2_addr, alu_enable, wb_valid, wb_addr,
                                    wb_data, wb_hi, z_flag_q, c_flag_q, illegal}, 0);
        check_counters("rst");
        #1 rst_n = 1'b1;

        // ADD R-type with latency checks
        issue(enc(4'h0, 1'b0, 5'd3, 5'd1, {5'd2, 12'h0}));
        @(negedge clk);
        check("add_rd_en_T1", rf_rd_en, 1);
        check("add_rs1_addr", rf_rs1_addr, 1);
        check("add_rs2_addr", rf_rs2_addr, 2);
        @(negedge clk);
        check("add_alu_en_T2", alu_enable, 1);
        check("add_rd_en_off_T2", rf_rd_en, 0);
        @(negedge clk);
        check("add_wb_valid_T3", wb_valid, 1);
        check("add_wb_data", wb_data, 12);
        wait_idle();

        // SUB I-type to zero, then MUL with non-zero high half
        issue(enc(4'h1, 1'b1, 5'd6, 5'd9, 17'd9));
        wait_idle();
        check("sub_z_flag", z_flag_q, 1);
        issue(enc(4'h2, 1'b0, 5'd5, 5'd10, {5'd11, 12'h0}));
        wait_idle();
        check("mul_c_flag", c_flag_q, 1);

        // rd = 0: flags update (borrow), no writeback
        issue(enc(4'h1, 1'b1, 5'd0, 5'd1, 17'd6));
        @(negedge clk);
        @(negedge clk);
        check("rd0_alu_en", alu_enable, 1);
        @(negedge clk);
        check("rd0_no_wb", wb_valid, 0);
        check("rd0_ready_T3", instr_ready, 1);
        check("rd0_c_flag", c_flag_q, 1);

        // Illegal opcodes E and F
        for (int k = 0; k < 2; k++) begin
            issue(enc(4'hE + 4'(k), 1'b0, 5'd4, 5'd1, {5'd2, 12'h0}));
            @(negedge clk);
            check("ill_pulse_T1", illegal, 1);
            check("ill_no_read", rf_rd_en, 0);
            @(negedge clk);
            check("ill_pulse_end", illegal, 0);
            check("ill_ready_T2", instr_ready, 1);
            check("ill_no_wb", wb_valid, 0);
            check("ill_z_kept", z_flag_q, mz);
            check("ill_c_kept", c_flag_q, mc);
        end
        check_counters("ill");

        // Writeback stall for 5 cycles, then back-to-back accept
        rdy_mode = 2;
        @(posedge clk);
        issue(enc(4'h8, 1'b0, 5'd8, 5'd10, {5'd11, 12'h0}));
        n = 0;
        while (!wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_wb_valid", wb_valid, 1);
            check("stall_wb_data", wb_data, 32'hFFFF_FFFD);
            check("stall_wb_addr", wb_addr, 8);
            check("stall_not_ready", instr_ready, 0);
            if (k < 4) @(negedge clk);
        end
        w2 = enc(4'h4, 1'b1, 5'd7, 5'd1, 17'h10);
        instr = w2;
        instr_valid = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check("hs_wb_valid", wb_valid, 1);
        check("hs_not_ready", instr_ready, 0);
        @(negedge clk);
        check("b2b_ready", instr_ready, 1);
        check("b2b_wb_dropped", wb_valid, 0);
        @(posedge clk);
        push_model(w2);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_rd_en", rf_rd_en, 1);
        wait_idle();

        // Reset during EXEC aborts everything
        issue(enc(4'h0, 1'b0, 5'd4, 5'd1, {5'd2, 12'h0}));
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", alu_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1);
        check("abort_outputs_zero", |{busy, rf_rd_en, alu_enable, alu_a, alu_opcode, wb_valid, wb_addr,
                                      wb_data, wb_hi, z_flag_q, c_flag_q, illegal}, 0);
        mz = 1'b0; mc = 1'b0; mret = 0; mill = 0;
        check_counters("abort");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_wb", wb_valid, 0);
        end

        // Randomized traffic with random writeback backpressure
        rdy_mode = 1;
        for (int t = 0; t < 80; t++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            issue(enc(4'($urandom), 1'($urandom), rd, 5'($urandom), 17'($urandom)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        wait_idle();
        @(negedge clk);
        check("drain_wbq", wbq.size(), 0);
        check("drain_flq", flq.size(), 0);
        check_counters("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
